fft_frame_collector: RTL and testbench
======================================

Name: fft_frame_collector

Overview:
Upstream neighbour of the FFT butterfly stage (FFT_step). Accepts one real sample per handshake from the audio front end and assembles SAMPLES of them into a frame. Presents each complete frame as a parallel unpacked array in the order that stage 0 of the FFT expects. Ping-pong double buffering lets the next frame fill while the FFT consumes the current one.

Parameters:
SAMPLES, 4, frame length; power of two, >= 2
WIDTH, 32, bits per sample (two's complement, passed through unmodified)
IDX_W, $clog2(SAMPLES), localparam; write index width

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
sample_in  input  WIDTH  incoming sample
sample_valid  input  1  sample_in valid this cycle
sample_sync  input  1  qualifies sample_valid; marks sample as index 0 of a new frame
sample_ready  output  1  collector can accept a sample this cycle
frame_out  output  [WIDTH-1:0] x [SAMPLES-1:0]  unpacked array; drives FFT_step sampleInputs
frame_valid  output  1  frame_out holds a complete frame
frame_ready  input  1  downstream consumes frame this cycle
frame_count  output  16  number of frames handed off, wraps at 65535->0

Behaviour:
- Storage: two banks (0, 1), each SAMPLES x WIDTH, plus full[1:0] flags, wr_bank, rd_bank and wr_idx (IDX_W bits).
- Reset (async): all bank words 0, full=00, wr_bank=0, rd_bank=0, wr_idx=0, frame_count=0. Outputs: sample_ready=1, frame_valid=0, frame_out all zeros.
- Reset asserted mid-frame or mid-handoff: partial frame and any full banks are discarded. No frame is emitted for them.
- sample_ready = !full[wr_bank]. Combinational from registered state; independent of sample_valid.
- Accept = sample_valid && sample_ready. On accept, the word is written to bank[wr_bank][addr(wr_idx)].
  - addr() is the identity by default; see Optional Feature.
  - wr_idx increments by 1.
- Sync: if accept && sample_sync, the sample is written at addr(0), any partial frame is discarded, and wr_idx becomes 1.
- sample_sync with sample_valid=0, or with sample_ready=0, is ignored.
- Frame complete: accept with wr_idx==SAMPLES-1 and no sync. Then set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
- Write FSM per bank: EMPTY -> FILLING (first accept) -> FULL (last accept) -> EMPTY (handoff).
- Latency: last sample accepted at edge N -> frame_valid=1 and frame_out valid after edge N (visible cycle N+1).
- frame_valid = full[rd_bank]. frame_out = bank[rd_bank] through a combinational mux. It is stable while frame_valid=1 && frame_ready=0.
- Handoff: frame_valid && frame_ready clears full[rd_bank], toggles rd_bank, and increments frame_count.
- frame_ready while frame_valid=0 has no effect.
- Both banks full: sample_ready=0 and input stalls. No data is lost or overwritten.
- Simultaneous frame completion into one bank and handoff of the other bank in the same cycle: both take effect. Back-to-back frames therefore flow with zero bubble at 1 sample/cycle when frame_ready=1.
- Handoff of bank X and a write into bank X never coincide, because a bank is written only when it is not full.

Optional Feature:
FFT_FRAME_BITREV_EN.
- Defined: addr(i) = bit-reversal of i over IDX_W bits, so frames are delivered in decimation-in-time input order. For SAMPLES=4 the mapping is 0->0, 1->2, 2->1, 3->3.
- Undefined: addr(i)=i, natural order; any reordering is left to the FFT stage.
- No other behaviour, port or latency changes.

Test Plan:
- Reset, then check state -> sample_ready=1, frame_valid=0, frame_out={0,0,0,0}, frame_count=0.
- Natural order, macro off: feed 100,200,150,250 on consecutive cycles with sync on the first, frame_ready=1 -> frame_valid one cycle after 250. frame_out[0..3]=100,200,150,250. frame_count=1 after the handoff edge.
- Macro on, same stimulus -> frame_out[0..3]=100,150,200,250.
- Backpressure: frame_ready=0, stream 12 samples 1..12 -> sample_ready drops after sample 8; samples 9..12 are held off. Raise frame_ready -> frames {1,2,3,4}, {5,6,7,8}, {9,10,11,12} emerge in order with no loss. frame_count=3.
- Resync: feed 7,8, then 30 with sync, then 31,32,33 -> first frame is 30,31,32,33; 7 and 8 are discarded.
- Async reset after 2 samples of a frame, with the other bank full -> frame_valid and full flags drop immediately without waiting for a clock edge. A following 4-sample frame emits normally from bank 0.

Source files
------------

// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector feeding FFT stage 0: SAMPLES words per frame, two banks.
// Optional macro FFT_FRAME_BITREV_EN stores samples at bit-reversed addresses (DIT input order).
module fft_frame_collector #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             sample_sync,
    output logic             sample_ready,
    output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [15:0]      frame_count
);

    localparam int IDX_W = $clog2(SAMPLES);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    logic [WIDTH-1:0] bank_q  [2][SAMPLES];
    logic [WIDTH-1:0] bank_d  [2][SAMPLES];
    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             accept;
    logic             handoff;
    logic             last_sample;
    logic [IDX_W-1:0] wr_slot;
    logic [IDX_W-1:0] wr_addr;

    function automatic logic [IDX_W-1:0] addr_map(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
`ifdef FFT_FRAME_BITREV_EN
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = idx[IDX_W-1-b];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    // A bank is only written while not full and only handed off while full,
    // so the write and the handoff below never touch the same bank.
    assign sample_ready = (state_q[wr_bank_q] != BANK_FULL);
    assign frame_valid  = (state_q[rd_bank_q] == BANK_FULL);
    assign frame_count  = frame_count_q;
    assign accept       = sample_valid && sample_ready;
    assign handoff      = frame_valid && frame_ready;
    assign wr_slot      = sample_sync ? '0 : wr_idx_q;
    assign wr_addr      = addr_map(wr_slot);
    assign last_sample  = !sample_sync && (wr_idx_q == IDX_W'(SAMPLES - 1));

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            frame_out[i] = bank_q[rd_bank_q][i];
        end
    end

    // NOTE: combinational next-state uses blocking '=' with every output defaulted
    // first, so no latch is inferred; the flops below take these with '<='.
    always_comb begin
        bank_d        = bank_q;
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_idx_d      = wr_idx_q;
        frame_count_d = frame_count_q;

        if (handoff) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
            frame_count_d      = frame_count_q + 16'd1;
        end

        if (accept) begin
            bank_d[wr_bank_q][wr_addr] = sample_in;
            if (last_sample) begin
                state_d[wr_bank_q] = BANK_FULL;
                wr_bank_d          = ~wr_bank_q;
                wr_idx_d           = '0;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                wr_idx_d           = wr_slot + 1'b1;
            end
        end
    end

    // NOTE: the bank storage is reset on purpose so frame_out reads all zeros
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BANK_EMPTY;
                for (int i = 0; i < SAMPLES; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            frame_count_q <= '0;
        end else begin
            bank_q        <= bank_d;
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: queue-based frame model checked every
// cycle, plus hand-computed literal expectations for each directed scenario.
module tb_fft_frame_collector;

    localparam int SAMPLES = 4;
    localparam int WIDTH   = 32;
    localparam int IDX_W   = 2;

    typedef logic [SAMPLES-1:0][WIDTH-1:0] frame_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_sync = 1'b0;
    logic             sample_ready;
    logic [WIDTH-1:0] frame_out [SAMPLES-1:0];
    logic             frame_valid;
    logic             frame_ready = 1'b0;
    logic [15:0]      frame_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_part[$];
    frame_t           m_pend[$];
    logic [15:0]      m_count = '0;

    fft_frame_collector #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_sync  (sample_sync),
        .sample_ready (sample_ready),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Position of the i-th arrived sample of a frame inside frame_out.
    function automatic int addr_of(input int i);
`ifdef FFT_FRAME_BITREV_EN
        int r = 0;
        for (int b = 0; b < IDX_W; b++) begin
            if (((i >> b) & 1) != 0) r = r + (1 << (IDX_W - 1 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    // Model: arrival-order partial frame plus a FIFO of at most two complete frames.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_part.delete();
            m_pend.delete();
            m_count = '0;
        end else begin : model_step
            bit     rdy;
            bit     hand;
            frame_t f;
            rdy  = (m_pend.size() < 2);
            hand = (m_pend.size() > 0) && frame_ready;
            if (hand) begin
                void'(m_pend.pop_front());
                m_count = m_count + 16'd1;
            end
            if (sample_valid && rdy) begin
                if (sample_sync) begin
                    m_part.delete();
                end
                m_part.push_back(sample_in);
                if (m_part.size() == SAMPLES) begin
                    for (int i = 0; i < SAMPLES; i++) f[i] = m_part[i];
                    m_pend.push_back(f);
                    m_part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("sample_ready", sample_ready, m_pend.size() < 2);
            check("frame_valid", frame_valid, m_pend.size() > 0);
            check("frame_count", frame_count, m_count);
            if (m_pend.size() > 0) begin
                for (int i = 0; i < SAMPLES; i++) begin
                    check($sformatf("frame_out[%0d]", addr_of(i)), frame_out[addr_of(i)], m_pend[0][i]);
                end
            end
        end
    end

    // Literal expectations are given in frame_out index order.
    task automatic check_frame(input string name, input int e0, input int e1, input int e2, input int e3);
        check({name, "[0]"}, frame_out[0], e0);
        check({name, "[1]"}, frame_out[1], e1);
        check({name, "[2]"}, frame_out[2], e2);
        check({name, "[3]"}, frame_out[3], e3);
    endtask

    task automatic send(input logic [WIDTH-1:0] v, input logic s);
        int waits = 0;
        sample_in    = v;
        sample_valid = 1'b1;
        sample_sync  = s;
        while (!sample_ready && waits < 64) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (!sample_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        sample_sync  = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        frame_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_sample_ready", sample_ready, 1);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_count", frame_count, 0);
        check_frame("rst_frame_out", 0, 0, 0, 0);
        #9 reset = 1'b0;
        @(posedge clk);
        #2;

        // frame_ready with nothing to hand off must not count.
        frame_ready = 1'b1;
        idle(3);
        check("idle_count", frame_count, 0);

        // Natural / bit-reversed order, one frame, consumer always ready.
        send(100, 1'b1);
        send(200, 1'b0);
        send(150, 1'b0);
        send(250, 1'b0);
        check("t1_valid", frame_valid, 1);
`ifdef FFT_FRAME_BITREV_EN
        check_frame("t1_frame", 100, 150, 200, 250);
`else
        check_frame("t1_frame", 100, 200, 150, 250);
`endif
        idle(1);
        check("t1_count", frame_count, 1);
        check("t1_valid_after", frame_valid, 0);

        // Backpressure: both banks fill, input stalls, then drains in order.
        do_reset();
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        check("bp_ready_low", sample_ready, 0);
        check("bp_count0", frame_count, 0);
`ifdef FFT_FRAME_BITREV_EN
        check_frame("bp_first", 1, 3, 2, 4);
`else
        check_frame("bp_first", 1, 2, 3, 4);
`endif
        fork
            begin
                for (int i = 9; i <= 12; i++) send(i, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                frame_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && frame_count != 16'd3; k++) idle(1);
        check("bp_count3", frame_count, 3);
        check("bp_drained", frame_valid, 0);

        // Resync discards the partial frame 7,8.
        do_reset();
        frame_ready = 1'b1;
        send(7, 1'b0);
        send(8, 1'b0);
        send(30, 1'b1);
        send(31, 1'b0);
        send(32, 1'b0);
        send(33, 1'b0);
        check("rs_valid", frame_valid, 1);
`ifdef FFT_FRAME_BITREV_EN
        check_frame("rs_frame", 30, 32, 31, 33);
`else
        check_frame("rs_frame", 30, 31, 32, 33);
`endif
        idle(1);
        check("rs_count", frame_count, 1);

        // Asynchronous reset with bank 0 full and bank 1 half filled.
        do_reset();
        for (int i = 1; i <= 6; i++) send(i, 1'b0);
        check("ar_valid_before", frame_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("ar_valid_now", frame_valid, 0);
        check("ar_ready_now", sample_ready, 1);
        check("ar_word0_now", frame_out[0], 0);
        @(posedge clk);
        #2;
        reset       = 1'b0;
        frame_ready = 1'b1;
        send(40, 1'b1);
        send(41, 1'b0);
        send(42, 1'b0);
        send(43, 1'b0);
        check("ar_valid_after", frame_valid, 1);
`ifdef FFT_FRAME_BITREV_EN
        check_frame("ar_frame", 40, 42, 41, 43);
`else
        check_frame("ar_frame", 40, 41, 42, 43);
`endif
        idle(1);
        check("ar_count", frame_count, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
